// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: passive checker for the VSYNC/HSYNC/RGB raster stream.
// Measures line and frame timing, counts lit pixels and tracks timing lock.
module vga_rx_monitor #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          SAMPLE_en,
  input  logic          HSYNC,
  input  logic          VSYNC,
  input  logic [2:0]    RGB,
  input  logic          ERR_CLR,
  output logic [HW-1:0] H_TOTAL,
  output logic [HW-1:0] H_PULSE,
  output logic [VW-1:0] V_TOTAL,
  output logic [VW-1:0] V_PULSE,
  output logic [19:0]   LIT_COUNT,
  output logic          FRAME_DONE,
  output logic          LOCKED,
  output logic          TIMING_ERR
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEEK = 2'd0, MEASURE = 2'd1, TRACK = 2'd2} state_t;
  state_t state_reg, state_next;

  // lane 0 carries HSYNC, lane 1 carries VSYNC
  logic [1:0] sync_in, s_sync, rise, fall;
  logic [2:0] s_rgb_reg;
  assign sync_in = {VSYNC, HSYNC};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      logic s_reg, p_reg;
      always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
          s_reg <= 1'b0;
          p_reg <= 1'b0;
        end else if (SAMPLE_en) begin
          s_reg <= sync_in[gi];
          p_reg <= s_reg;
        end
      end
      assign s_sync[gi] = s_reg;
      assign rise[gi]   = SAMPLE_en & s_reg & ~p_reg;
      assign fall[gi]   = SAMPLE_en & ~s_reg & p_reg;
    end
  endgenerate

  logic s_h, s_v, h_rise, h_fall, v_rise, v_fall;
  assign s_h    = s_sync[0];
  assign s_v    = s_sync[1];
  assign h_rise = rise[0];
  assign h_fall = fall[0];
  assign v_rise = rise[1];
  assign v_fall = fall[1];

  logic [HW-1:0] hcnt_reg, hcnt_next, hp_reg, hp_next;
  logic [VW-1:0] vcnt_reg, vcnt_next, vcnt_inc, vp_reg, vp_next;
  logic [19:0]   lit_reg, lit_next;

  logic [HW-1:0] h_total_reg, h_pulse_reg;
  logic [VW-1:0] v_total_reg, v_pulse_reg;
  logic [19:0]   lit_count_reg;
  logic          frame_done_reg, locked_reg, timing_err_reg, bad_reg;
  logic [MW-1:0] match_reg, match_inc;

  logic timeout, cap_h_total, cap_h_pulse, cap_v_pulse, frame_end, in_track;
  logic mismatch, frame_bad, err_set;

  assign timeout = SAMPLE_en & (state_reg != SEEK) & ((hcnt_reg == '1) | (vcnt_reg == '1));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_reg <= SEEK;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEEK:           if (v_rise) state_next = MEASURE;
      MEASURE, TRACK: if (timeout) state_next = SEEK;
                      else if (v_rise) state_next = TRACK;
      default:        state_next = SEEK;
    endcase
  end

  always_comb begin
    cap_h_total = 1'b0;
    cap_h_pulse = 1'b0;
    cap_v_pulse = 1'b0;
    frame_end   = 1'b0;
    in_track    = (state_reg == TRACK);
    case (state_reg)
      MEASURE, TRACK: if (!timeout) begin
        cap_h_total = h_rise;
        cap_h_pulse = h_fall;
        cap_v_pulse = v_fall;
        frame_end   = v_rise;
      end
      default: ;
    endcase
  end

  // A line starting on the V rise sample belongs to the frame that just ended,
  // but it is also the first line of the new VSYNC pulse.
  always_comb begin
    hcnt_next = hcnt_reg;
    if (h_rise) hcnt_next = HW'(1);
    else if (hcnt_reg != '1) hcnt_next = hcnt_reg + HW'(1);

    hp_next = hp_reg;
    if (h_rise) hp_next = HW'(1);
    else if (s_h && hp_reg != '1) hp_next = hp_reg + HW'(1);

    vcnt_inc = vcnt_reg;
    if (h_rise && vcnt_reg != '1) vcnt_inc = vcnt_reg + VW'(1);
    vcnt_next = v_rise ? '0 : vcnt_inc;

    vp_next = vp_reg;
    if (v_rise) vp_next = h_rise ? VW'(1) : '0;
    else if (h_rise && s_v && vp_reg != '1) vp_next = vp_reg + VW'(1);

    lit_next = lit_reg;
    if (v_rise) lit_next = '0;
    else if (s_rgb_reg != 3'b000 && !s_h && !s_v && lit_reg != '1) lit_next = lit_reg + 20'd1;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s_rgb_reg <= 3'b000;
      hcnt_reg  <= '0;
      hp_reg    <= '0;
      vcnt_reg  <= '0;
      vp_reg    <= '0;
      lit_reg   <= '0;
    end else if (SAMPLE_en) begin
      s_rgb_reg <= RGB;
      hcnt_reg  <= hcnt_next;
      hp_reg    <= hp_next;
      vcnt_reg  <= vcnt_next;
      vp_reg    <= vp_next;
      lit_reg   <= lit_next;
    end
  end

  assign mismatch = in_track & ((cap_h_total & (hcnt_reg != h_total_reg)) |
                                (cap_h_pulse & (hp_reg != h_pulse_reg)) |
                                (cap_v_pulse & (vp_reg != v_pulse_reg)) |
                                (frame_end & (vcnt_inc != v_total_reg)));
  assign frame_bad = bad_reg | mismatch;
  assign match_inc = (match_reg == MW'(LOCK_FRAMES)) ? match_reg : match_reg + MW'(1);
  assign err_set   = timeout | (frame_end & in_track & frame_bad);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      h_total_reg    <= '0;
      h_pulse_reg    <= '0;
      v_total_reg    <= '0;
      v_pulse_reg    <= '0;
      lit_count_reg  <= '0;
      frame_done_reg <= 1'b0;
      bad_reg        <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      bad_reg        <= (frame_end | timeout) ? 1'b0 : frame_bad;
      if (cap_h_total) h_total_reg <= hcnt_reg;
      if (cap_h_pulse) h_pulse_reg <= hp_reg;
      if (cap_v_pulse) v_pulse_reg <= vp_reg;
      if (frame_end) begin
        v_total_reg   <= vcnt_inc;
        lit_count_reg <= lit_reg;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      match_reg  <= '0;
      locked_reg <= 1'b0;
    end else if (timeout) begin
      match_reg  <= '0;
      locked_reg <= 1'b0;
    end else if (frame_end) begin
      if (!in_track) begin
        match_reg <= '0;
      end else if (frame_bad) begin
        match_reg  <= '0;
        locked_reg <= 1'b0;
      end else begin
        match_reg <= match_inc;
        if (match_inc == MW'(LOCK_FRAMES)) locked_reg <= 1'b1;
      end
    end
  end

  // A new error outranks a coincident clear request.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)      timing_err_reg <= 1'b0;
    else if (err_set) timing_err_reg <= 1'b1;
    else if (ERR_CLR) timing_err_reg <= 1'b0;
  end

  assign H_TOTAL    = h_total_reg;
  assign H_PULSE    = h_pulse_reg;
  assign V_TOTAL    = v_total_reg;
  assign V_PULSE    = v_pulse_reg;
  assign LIT_COUNT  = lit_count_reg;
  assign FRAME_DONE = frame_done_reg;
  assign LOCKED     = locked_reg;
  assign TIMING_ERR = timing_err_reg;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced raster geometry
// (64 samples x 30 lines) so every scenario stays short.
module tb_vga_rx_monitor;
  localparam int H_TOT  = 64;
  localparam int H_PW   = 8;
  localparam int H_ACT0 = 12;
  localparam int H_ACT  = 48;
  localparam int V_TOT  = 30;
  localparam int V_PW   = 2;
  localparam int V_ACT0 = 4;
  localparam int V_ACT  = 24;
  localparam int LIT_EXP = H_ACT * V_ACT;

  logic        CLK = 1'b0;
  logic        nRESET, SAMPLE_en, HSYNC, VSYNC, ERR_CLR;
  logic [2:0]  RGB;
  logic [10:0] H_TOTAL, H_PULSE;
  logic [9:0]  V_TOTAL, V_PULSE;
  logic [19:0] LIT_COUNT;
  logic        FRAME_DONE, LOCKED, TIMING_ERR;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int frame_num = 0;
  bit clr_release = 1'b0;

  vga_rx_monitor dut (
    .CLK(CLK), .nRESET(nRESET), .SAMPLE_en(SAMPLE_en), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .RGB(RGB), .ERR_CLR(ERR_CLR), .H_TOTAL(H_TOTAL), .H_PULSE(H_PULSE),
    .V_TOTAL(V_TOTAL), .V_PULSE(V_PULSE), .LIT_COUNT(LIT_COUNT),
    .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED), .TIMING_ERR(TIMING_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_DONE === 1'b1) fd_count++;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_sample(input bit h, input bit v, input logic [2:0] rgb, input int half);
    HSYNC = h; VSYNC = v; RGB = rgb; SAMPLE_en = 1'b1;
    @(posedge CLK); #1;
    if (clr_release && FRAME_DONE) begin ERR_CLR = 1'b0; clr_release = 1'b0; end
    if (half != 0) begin
      SAMPLE_en = 1'b0;
      @(posedge CLK); #1;
      if (clr_release && FRAME_DONE) begin ERR_CLR = 1'b0; clr_release = 1'b0; end
    end
  endtask

  task automatic send_frame(input int long_line, input int half, input int clr_line, input int nlines);
    int len;
    bit h, v, act;
    logic [2:0] rgb;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == long_line) ? H_TOT + 1 : H_TOT;
      if (clr_line >= 0 && ln >= clr_line) ERR_CLR = 1'b1;
      for (int px = 0; px < len; px++) begin
        h   = (px < H_PW);
        v   = (ln < V_PW);
        act = (ln >= V_ACT0) && (ln < V_ACT0 + V_ACT) && (px >= H_ACT0) && (px < H_ACT0 + H_ACT);
        if (act)         rgb = (px % 2 == 1) ? 3'b001 : 3'b111;
        else if (h || v) rgb = 3'b100;
        else             rgb = 3'b000;
        send_sample(h, v, rgb, half);
      end
    end
    frame_num++;
    $display("frame %0d: lines=%0d fd=%0d H_TOTAL=%0d H_PULSE=%0d V_TOTAL=%0d V_PULSE=%0d LIT=%0d LOCKED=%0b ERR=%0b",
             frame_num, nlines, fd_count, H_TOTAL, H_PULSE, V_TOTAL, V_PULSE, LIT_COUNT, LOCKED, TIMING_ERR);
  endtask

  task automatic pulse_reset();
    HSYNC = 0; VSYNC = 0; RGB = 0; SAMPLE_en = 0; ERR_CLR = 0;
    #3 nRESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRESET = 1'b1;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; SAMPLE_en = 0; HSYNC = 0; VSYNC = 0; RGB = 0; ERR_CLR = 0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (H_TOTAL !== 11'd0) begin errors++; $display("FAIL reset_h_total: got %0d, expected 0", H_TOTAL); end
    checks++; if (V_TOTAL !== 10'd0) begin errors++; $display("FAIL reset_v_total: got %0d, expected 0", V_TOTAL); end
    checks++; if (LIT_COUNT !== 20'd0) begin errors++; $display("FAIL reset_lit: got %0d, expected 0", LIT_COUNT); end
    checks++; if ({FRAME_DONE, LOCKED, TIMING_ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, expected 000", {FRAME_DONE, LOCKED, TIMING_ERR}); end
    nRESET = 1'b1;
    $display("reset released");
  endtask

  task automatic test_standard_frame();
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== 0) begin errors++; $display("FAIL std_no_fd_first_vrise: got %0d, expected 0", fd_count); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== 1) begin errors++; $display("FAIL std_fd_second_vrise: got %0d, expected 1", fd_count); end
    checks++; if (H_TOTAL !== 11'(H_TOT)) begin errors++; $display("FAIL std_h_total: got %0d, expected %0d", H_TOTAL, H_TOT); end
    checks++; if (H_PULSE !== 11'(H_PW)) begin errors++; $display("FAIL std_h_pulse: got %0d, expected %0d", H_PULSE, H_PW); end
    checks++; if (V_TOTAL !== 10'(V_TOT)) begin errors++; $display("FAIL std_v_total: got %0d, expected %0d", V_TOTAL, V_TOT); end
    checks++; if (V_PULSE !== 10'(V_PW)) begin errors++; $display("FAIL std_v_pulse: got %0d, expected %0d", V_PULSE, V_PW); end
    checks++; if (LIT_COUNT !== 20'(LIT_EXP)) begin errors++; $display("FAIL std_lit: got %0d, expected %0d", LIT_COUNT, LIT_EXP); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL std_not_locked_fd2: got %b, expected 0", LOCKED); end
    send_frame(-1, 0, -1, V_TOT);
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== 4) begin errors++; $display("FAIL std_fd_count: got %0d, expected 4", fd_count); end
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL std_locked_fd4: got %b, expected 1", LOCKED); end
    checks++; if (TIMING_ERR !== 1'b0) begin errors++; $display("FAIL std_no_err: got %b, expected 0", TIMING_ERR); end
  endtask

  task automatic test_line_mismatch();
    send_frame(10, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL mm_locked_before_report: got %b, expected 1", LOCKED); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL mm_unlocked: got %b, expected 0", LOCKED); end
    checks++; if (TIMING_ERR !== 1'b1) begin errors++; $display("FAIL mm_err_set: got %b, expected 1", TIMING_ERR); end
    checks++; if (V_TOTAL !== 10'(V_TOT)) begin errors++; $display("FAIL mm_v_total: got %0d, expected %0d", V_TOTAL, V_TOT); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL mm_one_good_frame: got %b, expected 0", LOCKED); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL mm_relocked: got %b, expected 1", LOCKED); end
    checks++; if (TIMING_ERR !== 1'b1) begin errors++; $display("FAIL mm_err_sticky: got %b, expected 1", TIMING_ERR); end
  endtask

  task automatic test_err_clr();
    SAMPLE_en = 1'b0; ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    checks++; if (TIMING_ERR !== 1'b0) begin errors++; $display("FAIL clr_while_disabled: got %b, expected 0", TIMING_ERR); end
    checks++; if (H_TOTAL !== 11'(H_TOT)) begin errors++; $display("FAIL clr_no_side_effect: got %0d, expected %0d", H_TOTAL, H_TOT); end
    $display("err_clr pulse applied with SAMPLE_en=0");
  endtask

  task automatic test_hsync_stuck();
    int fd0;
    for (int i = 0; i < 2100; i++) send_sample(1'b0, 1'b0, 3'b000, 0);
    $display("hsync held low for 2100 samples: LOCKED=%0b ERR=%0b H_TOTAL=%0d", LOCKED, TIMING_ERR, H_TOTAL);
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL stuck_unlocked: got %b, expected 0", LOCKED); end
    checks++; if (TIMING_ERR !== 1'b1) begin errors++; $display("FAIL stuck_err: got %b, expected 1", TIMING_ERR); end
    checks++; if (H_TOTAL !== 11'(H_TOT)) begin errors++; $display("FAIL stuck_h_total_hold: got %0d, expected %0d", H_TOTAL, H_TOT); end
    fd0 = fd_count;
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== fd0) begin errors++; $display("FAIL stuck_seek_no_fd: got %0d, expected %0d", fd_count, fd0); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== fd0 + 1) begin errors++; $display("FAIL stuck_remeasure_fd: got %0d, expected %0d", fd_count, fd0 + 1); end
  endtask

  task automatic test_half_rate();
    int fd0;
    pulse_reset();
    fd0 = fd_count;
    send_frame(-1, 1, -1, V_TOT);
    send_frame(-1, 1, -1, V_TOT);
    checks++; if (fd_count !== fd0 + 1) begin errors++; $display("FAIL half_fd_single: got %0d, expected %0d", fd_count, fd0 + 1); end
    checks++; if (H_TOTAL !== 11'(H_TOT)) begin errors++; $display("FAIL half_h_total: got %0d, expected %0d", H_TOTAL, H_TOT); end
    checks++; if (H_PULSE !== 11'(H_PW)) begin errors++; $display("FAIL half_h_pulse: got %0d, expected %0d", H_PULSE, H_PW); end
    checks++; if (V_TOTAL !== 10'(V_TOT)) begin errors++; $display("FAIL half_v_total: got %0d, expected %0d", V_TOTAL, V_TOT); end
    checks++; if (V_PULSE !== 10'(V_PW)) begin errors++; $display("FAIL half_v_pulse: got %0d, expected %0d", V_PULSE, V_PW); end
    checks++; if (LIT_COUNT !== 20'(LIT_EXP)) begin errors++; $display("FAIL half_lit: got %0d, expected %0d", LIT_COUNT, LIT_EXP); end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    send_frame(-1, 0, -1, V_TOT);
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL rstmid_locked_before: got %b, expected 1", LOCKED); end
    send_frame(-1, 0, -1, 10);
    #3 nRESET = 1'b0;
    #1;
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rstmid_locked: got %b, expected 0", LOCKED); end
    checks++; if (H_TOTAL !== 11'd0) begin errors++; $display("FAIL rstmid_h_total: got %0d, expected 0", H_TOTAL); end
    checks++; if (LIT_COUNT !== 20'd0) begin errors++; $display("FAIL rstmid_lit: got %0d, expected 0", LIT_COUNT); end
    checks++; if (V_PULSE !== 10'd0) begin errors++; $display("FAIL rstmid_v_pulse: got %0d, expected 0", V_PULSE); end
    HSYNC = 0; VSYNC = 0; RGB = 0; SAMPLE_en = 0;
    repeat (2) @(posedge CLK);
    #1 nRESET = 1'b1;
    fd0 = fd_count;
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== fd0) begin errors++; $display("FAIL rstmid_no_fd_first: got %0d, expected %0d", fd_count, fd0); end
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (fd_count !== fd0 + 1) begin errors++; $display("FAIL rstmid_fd_second: got %0d, expected %0d", fd_count, fd0 + 1); end
  endtask

  task automatic test_clr_coincident();
    send_frame(10, 0, 20, V_TOT);
    checks++; if (TIMING_ERR !== 1'b0) begin errors++; $display("FAIL coin_err_before: got %b, expected 0", TIMING_ERR); end
    clr_release = 1'b1;
    send_frame(-1, 0, -1, V_TOT);
    checks++; if (TIMING_ERR !== 1'b1) begin errors++; $display("FAIL coin_set_wins: got %b, expected 1", TIMING_ERR); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL coin_unlocked: got %b, expected 0", LOCKED); end
  endtask

  initial begin
    test_reset();
    test_standard_frame();
    test_line_mismatch();
    test_err_clr();
    test_hsync_stuck();
    test_half_rate();
    test_reset_mid_frame();
    test_clr_coincident();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
